// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 16-bit pipelined MIPS core.
// Holds the 8x16 register file (r0 hardwired to zero, same-cycle write-back
// bypass), decodes the opcode into the ID/EX control bundle, sign-extends the
// 6-bit immediate, detects load-use hazards against the instruction in ID/EX,
// and keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_instr, in_PC_plus_two   instruction and PC+2 from IF/ID
//   in_flush                   squash the instruction currently in decode
//   wb_RegWrite/wb_rd/wb_data  register file write-back port
//   ex_MemRead, ex_rt          load status / destination of the ID/EX instruction
//   O_PC_plus_two, O_Read_data_1/2, O_immediate, O_rt, O_rd   data/fields to ID/EX
//   O_ALU_Src .. O_RegWrite    control bundle to ID/EX
//   O_stall                    hold PC and IF/ID this cycle
//   O_stall_count              saturating count of stall cycles since reset
module id_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            in_instr,
    input  logic [15:0]            in_PC_plus_two,
    input  logic                   in_flush,
    input  logic                   wb_RegWrite,
    input  logic [2:0]             wb_rd,
    input  logic [15:0]            wb_data,
    input  logic                   ex_MemRead,
    input  logic [2:0]             ex_rt,
    output logic [15:0]            O_PC_plus_two,
    output logic [15:0]            O_Read_data_1,
    output logic [15:0]            O_Read_data_2,
    output logic [15:0]            O_immediate,
    output logic [2:0]             O_rt,
    output logic [2:0]             O_rd,
    output logic                   O_ALU_Src,
    output logic [1:0]             O_ALUOp,
    output logic                   O_RegDest,
    output logic                   O_MemRead,
    output logic                   O_MemWrite,
    output logic                   O_Branch,
    output logic                   O_MemtoReg,
    output logic                   O_RegWrite,
    output logic                   O_stall,
    output logic [STALL_CNT_W-1:0] O_stall_count
);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_LW    = 4'b0001,
        OP_SW    = 4'b0010,
        OP_BEQ   = 4'b0011,
        OP_ADDI  = 4'b0100
    } opcode_e;

    opcode_e    opcode;
    logic [2:0] rs;
    logic [2:0] rt;

    logic [15:0] regs [8];
    logic        wb_en;

    logic        known_op;
    logic        uses_rt;
    logic        stall;
    logic        bubble;

    // decoded bundle before bubble masking
    logic        dec_alu_src;
    logic [1:0]  dec_aluop;
    logic        dec_regdest;
    logic        dec_memread;
    logic        dec_memwrite;
    logic        dec_branch;
    logic        dec_memtoreg;
    logic        dec_regwrite;

    assign opcode = opcode_e'(in_instr[15:12]);
    assign rs     = in_instr[11:9];
    assign rt     = in_instr[8:6];

    assign O_PC_plus_two = in_PC_plus_two;
    assign O_immediate   = {{10{in_instr[5]}}, in_instr[5:0]};
    assign O_rt          = rt;
    assign O_rd          = in_instr[5:3];

    // Register file; r0 is never written so it holds its reset value of zero.
    assign wb_en = wb_RegWrite && (wb_rd != 3'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read ports: r0 forced to zero, write-back data bypassed in its write cycle.
    always_comb begin
        O_Read_data_1 = regs[rs];
        if (rs == 3'd0) begin
            O_Read_data_1 = '0;
        end else if (wb_en && (wb_rd == rs)) begin
            O_Read_data_1 = wb_data;
        end
    end

    always_comb begin
        O_Read_data_2 = regs[rt];
        if (rt == 3'd0) begin
            O_Read_data_2 = '0;
        end else if (wb_en && (wb_rd == rt)) begin
            O_Read_data_2 = wb_data;
        end
    end

    // Opcode decode
    always_comb begin
        dec_alu_src  = 1'b0;
        dec_aluop    = 2'b00;
        dec_regdest  = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        known_op     = 1'b1;
        uses_rt      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_aluop    = 2'b10;
                dec_regdest  = 1'b1;
                dec_regwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_LW: begin
                dec_alu_src  = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_SW: begin
                dec_alu_src  = 1'b1;
                dec_memwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_BEQ: begin
                dec_aluop    = 2'b01;
                dec_branch   = 1'b1;
                uses_rt      = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_src  = 1'b1;
                dec_regwrite = 1'b1;
            end
            default: begin
                known_op = 1'b0;
            end
        endcase
    end

    // Load-use hazard; a flush in the same cycle wins because the instruction
    // is being squashed anyway, and nothing stalls while in reset.
    always_comb begin
        stall = 1'b0;
        if (rst_n && !in_flush && known_op && ex_MemRead && (ex_rt != 3'd0)) begin
            stall = (ex_rt == rs) || (uses_rt && (ex_rt == rt));
        end
    end

    assign O_stall = stall;
    assign bubble  = !rst_n || stall || in_flush;

    always_comb begin
        O_ALU_Src  = dec_alu_src;
        O_ALUOp    = dec_aluop;
        O_RegDest  = dec_regdest;
        O_MemRead  = dec_memread;
        O_MemWrite = dec_memwrite;
        O_Branch   = dec_branch;
        O_MemtoReg = dec_memtoreg;
        O_RegWrite = dec_regwrite;
        if (bubble) begin
            O_ALU_Src  = 1'b0;
            O_ALUOp    = 2'b00;
            O_RegDest  = 1'b0;
            O_MemRead  = 1'b0;
            O_MemWrite = 1'b0;
            O_Branch   = 1'b0;
            O_MemtoReg = 1'b0;
            O_RegWrite = 1'b0;
        end
    end

    // Saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            O_stall_count <= '0;
        end else if (stall && (O_stall_count != '1)) begin
            O_stall_count <= O_stall_count + 1'b1;
        end
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 16-bit pipelined MIPS core, sitting between the IF/ID register and the ID/EX pipeline register. It holds the 8×16 register file, decodes the instruction into the control bundle the ID/EX register latches, and sign-extends the immediate. It also detects load-use hazards against the instruction currently in ID/EX and inserts bubbles, keeping a saturating stall counter for performance monitoring.

## Interface
- STALL_CNT_W, 16, width of the saturating stall counter
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_instr  in  16  instruction from IF/ID: opcode[15:12], rs[11:9], rt[8:6], rd[5:3], imm[5:0]
- in_PC_plus_two  in  16  PC+2 from IF/ID
- in_flush  in  1  branch taken in a later stage; squash current decode
- wb_RegWrite  in  1  write-back enable
- wb_rd  in  3  write-back register index
- wb_data  in  16  write-back data
- ex_MemRead  in  1  MemRead of instruction now held in ID/EX
- ex_rt  in  3  destination rt of instruction now held in ID/EX
- O_PC_plus_two  out  16  pass-through of in_PC_plus_two
- O_Read_data_1 / O_Read_data_2  out  16  register file read of rs / rt
- O_immediate  out  16  imm[5:0] sign-extended
- O_rt / O_rd  out  3  instruction fields [8:6] / [5:3]
- O_ALU_Src, O_ALUOp[1:0], O_RegDest, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite  out  control bundle for ID/EX
- O_stall  out  1  hold PC and IF/ID this cycle
- O_stall_count  out  STALL_CNT_W  number of stall cycles since reset

## Operation
- Register file: 8×16, r0 reads 0 always and ignores writes. Write on rising clk when wb_RegWrite=1 and wb_rd≠0.
- Read bypass: if wb_RegWrite=1, wb_rd≠0 and wb_rd equals the read index, read port returns wb_data in the same cycle.
- Reset: at rising clk with rst_n=0, all registers ← 0, O_stall_count ← 0. While rst_n=0, all control outputs and O_stall are forced 0; write-back writes are ignored.
- Decode (opcode → ALU_Src, ALUOp, RegDest, MemRead, MemWrite, Branch, MemtoReg, RegWrite):
  - 0000 R-type: 0,10,1,0,0,0,0,1
  - 0001 LW: 1,00,0,1,0,0,1,1
  - 0010 SW: 1,00,0,0,1,0,0,0
  - 0011 BEQ: 0,01,0,0,0,1,0,0
  - 0100 ADDI: 1,00,0,0,0,0,0,1
  - others: all 0 (NOP)
- Hazard: O_stall=1 when ex_MemRead=1, ex_rt≠0 and (ex_rt==rs, or ex_rt==rt for opcodes 0000/0010/0011). Not raised for NOP opcodes.
- Bubble: when O_stall=1 or in_flush=1, all control outputs forced 0; data/field outputs pass through unchanged.
- in_flush has priority: in_flush=1 forces O_stall=0.
- Stall counter: +1 at each rising clk where O_stall=1; saturates at all-ones, no wrap.

## Timing
- Decode, hazard, bypass and read outputs are combinational from inputs and register state; zero-cycle latency, consumed by ID/EX on its latch edge.
- Register write visible at read ports via bypass in the write cycle, from array thereafter.
- Load-use produces exactly one stall cycle: next cycle ID/EX holds the bubble (ex_MemRead=0), so O_stall drops.
- Reset mid-operation: next edge clears state regardless of wb_RegWrite or O_stall.

## Test plan
- Reset then read r0..r7 -> all O_Read_data = 0x0000, O_stall_count = 0, all controls 0 while rst_n=0.
- Write r3=0xBEEF via WB, same cycle decode rs=3 -> O_Read_data_1=0xBEEF (bypass); next cycle still 0xBEEF; write r0=0x1234 -> r0 reads 0.
- Decode LW with imm=6'b111100 -> O_immediate=0xFFFC, controls 1,00,0,1,0,0,1,1; each opcode 0000–0100 and 1111 checked against table.
- ex_MemRead=1, ex_rt=2, R-type rt=2 -> O_stall=1, controls 0, count+1; same with ADDI rt=2 (rs≠2) -> O_stall=0.
- Load-use with in_flush=1 -> O_stall=0, controls 0, count unchanged.
- Force 2^STALL_CNT_W+3 stall cycles (STALL_CNT_W=4) -> count holds 0xF.
